// File: rtl/ceyloniac_pkg.sv
// Shared definitions for the Ceyloniac operand stage: default widths,
// the hard-wired zero register and the stage occupancy encoding.
package ceyloniac_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned ZERO_REG       = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/ceyloniac_operand_fwd.sv
// Write-back patch unit for one operand bundle: any operand whose source
// register matches a live, non-zero write-back address takes wb_data.
module ceyloniac_operand_fwd
    import ceyloniac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_OPS    = 2
) (
    input  logic                          wb_en,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] data,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0] addr,
    output logic [NUM_OPS*DATA_WIDTH-1:0] data_fwd_c
);

    logic hit_en_c;

    // Register 0 is architecturally constant and never forwarded.
    assign hit_en_c = wb_en && (wb_addr != ADDR_WIDTH'(ZERO_REG));

    // Per-operand compare and replace.
    always_comb begin
        data_fwd_c = data;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            if (hit_en_c && (addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wb_addr)) begin
                data_fwd_c[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
            end
        end
    end

endmodule

// File: rtl/ceyloniac_operand_stage.sv
// Register-read to execute stage: NUM_OPS operands with valid/ready and a
// one-entry skid so in_ready is purely registered. Synchronous flush squashes
// everything held. Define CEYLONIAC_WB_FORWARD_EN to patch held operands with
// matching write-backs; otherwise the wb_* inputs have no effect.
module ceyloniac_operand_stage
    import ceyloniac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_OPS    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_OPS*ADDR_WIDTH-1:0] in_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_OPS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OPS*ADDR_WIDTH-1:0] out_addr,
    input  logic                          wb_en,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data
);

    localparam int unsigned DW_ALL = NUM_OPS * DATA_WIDTH;
    localparam int unsigned AW_ALL = NUM_OPS * ADDR_WIDTH;

`ifdef CEYLONIAC_WB_FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    state_t            state;
    logic [DW_ALL-1:0] main_data;
    logic [AW_ALL-1:0] main_addr;
    logic [DW_ALL-1:0] skid_data;
    logic [AW_ALL-1:0] skid_addr;

    logic              fwd_en_c;
    logic              accept_c;
    logic              pop_c;
    logic [DW_ALL-1:0] in_fwd_c;
    logic [DW_ALL-1:0] main_fwd_c;
    logic [DW_ALL-1:0] skid_fwd_c;

    assign fwd_en_c  = wb_en & FWD_ON;
    assign accept_c  = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;
    assign out_data  = main_data;
    assign out_addr  = main_addr;

    ceyloniac_operand_fwd #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OPS    (NUM_OPS)
    ) u_fwd_in (
        .wb_en      (fwd_en_c),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .data       (in_data),
        .addr       (in_addr),
        .data_fwd_c (in_fwd_c)
    );

    ceyloniac_operand_fwd #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OPS    (NUM_OPS)
    ) u_fwd_main (
        .wb_en      (fwd_en_c),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .data       (main_data),
        .addr       (main_addr),
        .data_fwd_c (main_fwd_c)
    );

    ceyloniac_operand_fwd #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OPS    (NUM_OPS)
    ) u_fwd_skid (
        .wb_en      (fwd_en_c),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .data       (skid_data),
        .addr       (skid_addr),
        .data_fwd_c (skid_fwd_c)
    );

    // Occupancy FSM with registered handshake outputs; entries that stay
    // resident always reload through their patch unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_addr <= '0;
            skid_data <= '0;
            skid_addr <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_addr <= '0;
            skid_data <= '0;
            skid_addr <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        main_data <= in_fwd_c;
                        main_addr <= in_addr;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && pop_c) begin
                        main_data <= in_fwd_c;
                        main_addr <= in_addr;
                    end else if (accept_c) begin
                        main_data <= main_fwd_c;
                        skid_data <= in_fwd_c;
                        skid_addr <= in_addr;
                        in_ready  <= 1'b0;
                        state     <= ST_FULL;
                    end else if (pop_c) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else begin
                        main_data <= main_fwd_c;
                    end
                end
                ST_FULL: begin
                    if (pop_c) begin
                        main_data <= skid_fwd_c;
                        main_addr <= skid_addr;
                        in_ready  <= 1'b1;
                        state     <= ST_ONE;
                    end else begin
                        main_data <= main_fwd_c;
                        skid_data <= skid_fwd_c;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceyloniac_operand_stage.sv
// Directed bench for ceyloniac_operand_stage with a FIFO scoreboard model.
module tb_ceyloniac_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NO = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [NO*DW-1:0] in_data;
    logic [NO*AW-1:0] in_addr;
    logic             out_valid;
    logic             out_ready;
    logic [NO*DW-1:0] out_data;
    logic [NO*AW-1:0] out_addr;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;

    typedef struct {
        logic [NO*DW-1:0] d;
        logic [NO*AW-1:0] a;
    } bundle_t;

    bundle_t q[$];
    int      ncheck = 0;
    int      npass  = 0;
    int      nfail  = 0;
    logic [NO*DW-1:0] held;

    ceyloniac_operand_stage #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_OPS    (NO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write-back patch of a resident bundle.
    function automatic bundle_t patch(bundle_t b);
`ifdef CEYLONIAC_WB_FORWARD_EN
        if (wb_en && wb_addr != '0) begin
            for (int i = 0; i < int'(NO); i++) begin
                if (b.a[i*AW +: AW] == wb_addr) b.d[i*DW +: DW] = wb_data;
            end
        end
`endif
        return b;
    endfunction

    // Check handshake/output against the model, advance the model, then clock.
    task automatic tick(input string tag);
        bundle_t exp;
        bundle_t nb;
        int      n0;
        bit      acc;
        n0 = q.size();
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(n0 > 0));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(n0 < 2));
        acc = in_valid && (n0 < 2);
        if (n0 > 0 && out_ready) begin
            exp = q.pop_front();
            chk({tag, ".out_data"}, 64'(out_data), 64'(exp.d));
            chk({tag, ".out_addr"}, 64'(out_addr), 64'(exp.a));
        end
        if (flush) begin
            q.delete();
        end else begin
            for (int i = 0; i < q.size(); i++) q[i] = patch(q[i]);
            if (acc) begin
                nb.d = in_data;
                nb.a = in_addr;
                q.push_back(patch(nb));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = {32'hDEAD, 32'hBEEF}; in_addr = {5'd3, 5'd4};
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.out_valid", 64'(out_valid), 64'd0);
        chk("rst_hold.in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // First accept, latency one cycle.
        in_data = {32'h22, 32'h11}; in_addr = {5'd2, 5'd1};
        tick("first");
        chk("first.valid", 64'(out_valid), 64'd1);
        chk("first.data", 64'(out_data), 64'h00000022_00000011);
        in_valid = 1'b0; out_ready = 1'b1;
        tick("drain0");

        // Fill to FULL, refuse C, then drain A, B, C back to back.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'hA1, 32'hA0}; in_addr = {5'd11, 5'd10};
        tick("push_a");
        in_data = {32'hB1, 32'hB0}; in_addr = {5'd13, 5'd12};
        tick("push_b");
        chk("full.in_ready", 64'(in_ready), 64'd0);
        in_data = {32'hC1, 32'hC0}; in_addr = {5'd15, 5'd14};
        tick("c_refused");
        out_ready = 1'b1;
        tick("pop_a");
        tick("pop_b_push_c");
        in_valid = 1'b0;
        tick("pop_c");
        tick("empty");

        // Streaming, one bundle per cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = {$urandom, $urandom};
            in_addr = 10'($urandom);
            tick("stream");
        end
        in_valid = 1'b0;
        tick("stream_tail");
        tick("stream_idle");

        // Flush from FULL with a bundle offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'h1, 32'h2}; in_addr = {5'd1, 5'd2};
        tick("fill1");
        in_data = {32'h3, 32'h4}; in_addr = {5'd3, 5'd4};
        tick("fill2");
        in_data = {32'hD1, 32'hD0}; in_addr = {5'd9, 5'd8};
        flush = 1'b1;
        tick("flush");
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.in_ready", 64'(in_ready), 64'd1);
        chk("flush.out_data", 64'(out_data), 64'd0);
        chk("flush.out_addr", 64'(out_addr), 64'd0);
        out_ready = 1'b1;
        tick("post_flush1");
        tick("post_flush2");

        // Held data survives going empty.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'hE1, 32'hE0}; in_addr = {5'd17, 5'd16};
        held = in_data;
        tick("push_e");
        in_valid = 1'b0; out_ready = 1'b1;
        tick("pop_e");
        chk("held.out_valid", 64'(out_valid), 64'd0);
        chk("held.out_data", 64'(out_data), 64'(held));

        // Write-back on a matching held operand.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'h77, 32'h1}; in_addr = {5'd7, 5'd5};
        tick("fwd_push");
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
        tick("fwd_wb");
        wb_en = 1'b0;
`ifdef CEYLONIAC_WB_FORWARD_EN
        chk("fwd.op0", 64'(out_data[DW-1:0]), 64'h0000ABCD);
`else
        chk("fwd.op0", 64'(out_data[DW-1:0]), 64'h1);
`endif
        chk("fwd.op1", 64'(out_data[2*DW-1:DW]), 64'h77);
        out_ready = 1'b1;
        tick("fwd_pop");

        // Write-back to register 0 never patches.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'h88, 32'h2}; in_addr = {5'd6, 5'd0};
        tick("r0_push");
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hABCD;
        tick("r0_wb");
        wb_en = 1'b0;
        chk("r0.op0", 64'(out_data[DW-1:0]), 64'h2);
        out_ready = 1'b1;
        tick("r0_pop");
        tick("r0_idle");

        // Asynchronous reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = {32'hF1, 32'hF0}; in_addr = {5'd19, 5'd18};
        tick("rf_fill1");
        in_data = {32'hF3, 32'hF2}; in_addr = {5'd21, 5'd20};
        tick("rf_fill2");
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.out_data", 64'(out_data), 64'd0);
        chk("arst.out_addr", 64'(out_addr), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        tick("post_arst");

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
